// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the parametrised synchronous FIFO.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit thresh_ok(input int depth, input int af, input int ae);
        return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer handshake bundle of the synchronous FIFO.
interface sync_fifo_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             flush;
    logic             write_en;
    logic [WIDTH-1:0] write_data;
    logic             read_en;
    logic [WIDTH-1:0] read_data;
    logic             read_valid;
    logic             mem_full;
    logic             mem_empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, write_en, write_data, read_en,
        input  read_data, read_valid, mem_full, mem_empty,
               almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, write_en, write_data, read_en,
        output read_data, read_valid, mem_full, mem_empty,
               almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ptr_w(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic [ptr_w(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]        rdata
);
    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage write; contents deliberately carry no reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy, thresholds, sticky errors,
// synchronous flush and selectable standard / first-word-fall-through read.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter bit FWFT      = 1'b0
) (
    input  logic               clk,
    input  logic               rst_l,
    sync_fifo_param_if.slave   bus
);
    localparam int         PW   = ptr_w(DEPTH);
    localparam int         CW   = PW + 1;
    localparam fifo_mode_e MODE = FWFT ? FIFO_FWFT : FIFO_STD;

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of 2 and >= 2");
    end
    if (!thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
        $error("sync_fifo_param: AF_THRESH or AE_THRESH out of range");
    end

    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic             full_r;
    logic             empty_r;
    logic             almost_full_r;
    logic             almost_empty_r;
    logic             overflow_r;
    logic             underflow_r;
    logic             rd_acc_s;
    logic             wr_acc_s;
    logic             mem_we_s;
    logic [WIDTH-1:0] mem_rdata_s;

    // Accept decisions from registered state; a push at full rides on a same-cycle pop
    always_comb begin
        rd_acc_s = bus.read_en && !empty_r;
        wr_acc_s = bus.write_en && (!full_r || rd_acc_s);
        mem_we_s = wr_acc_s && !bus.flush;
    end

    // Next occupancy; flush wins over any push/pop
    always_comb begin
        count_next_s = count_r;
        if (bus.flush) begin
            count_next_s = '0;
        end else begin
            count_next_s = count_r + CW'(wr_acc_s) - CW'(rd_acc_s);
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (wr_ptr_r),
        .wdata (bus.write_data),
        .raddr (rd_ptr_r),
        .rdata (mem_rdata_s)
    );

    // Pointers, occupancy and flags registered together so flags track count exactly
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
            count_r        <= '0;
            full_r         <= 1'b0;
            empty_r        <= 1'b1;
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
        end else begin
            if (bus.flush) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
            end else begin
                wr_ptr_r <= wr_ptr_r + PW'(wr_acc_s);
                rd_ptr_r <= rd_ptr_r + PW'(rd_acc_s);
            end
            count_r        <= count_next_s;
            full_r         <= (count_next_s == CW'(DEPTH));
            empty_r        <= (count_next_s == '0);
            almost_full_r  <= (count_next_s >= CW'(AF_THRESH));
            almost_empty_r <= (count_next_s <= CW'(AE_THRESH));
        end
    end

    // Sticky error flags, cleared only by flush or reset
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (bus.flush) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= overflow_r  | (bus.write_en && !wr_acc_s);
            underflow_r <= underflow_r | (bus.read_en && empty_r);
        end
    end

    if (MODE == FIFO_STD) begin : g_std
        logic [WIDTH-1:0] read_data_r;
        logic             read_valid_r;

        // Registered pop: data appears one cycle after an accepted read, then holds
        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
                read_data_r  <= '0;
                read_valid_r <= 1'b0;
            end else if (bus.flush) begin
                read_valid_r <= 1'b0;
            end else if (rd_acc_s) begin
                read_data_r  <= mem_rdata_s;
                read_valid_r <= 1'b1;
            end else begin
                read_valid_r <= 1'b0;
            end
        end

        assign bus.read_data  = read_data_r;
        assign bus.read_valid = read_valid_r;
    end else begin : g_fwft
        // Head word is presented directly from storage, masked to zero when empty
        assign bus.read_valid = !empty_r;
        assign bus.read_data  = empty_r ? '0 : mem_rdata_s;
    end

    assign bus.count        = count_r;
    assign bus.mem_full     = full_r;
    assign bus.mem_empty    = empty_r;
    assign bus.almost_full  = almost_full_r;
    assign bus.almost_empty = almost_empty_r;
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: a standard-mode and an FWFT-mode FIFO (8 x 8, AF=6, AE=2).
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic rst_l;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.WIDTH(8), .DEPTH(8)) bs ();
    sync_fifo_param_if #(.WIDTH(8), .DEPTH(8)) bf ();

    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b0))
        dut_std (.clk(clk), .rst_l(rst_l), .bus(bs));
    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b1))
        dut_fwft (.clk(clk), .rst_l(rst_l), .bus(bf));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic std_idle();
        bs.flush = 1'b0; bs.write_en = 1'b0; bs.read_en = 1'b0; bs.write_data = 8'h00;
    endtask

    task automatic std_flush();
        std_idle();
        bs.flush = 1'b1;
        step();
        bs.flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        std_idle();
        bf.flush = 1'b0; bf.write_en = 1'b0; bf.read_en = 1'b0; bf.write_data = 8'h00;
        #12;
        rst_l = 1'b1;
        step();
        checks++;
        if ({bs.count, bs.mem_empty, bs.almost_empty, bs.mem_full, bs.almost_full,
             bs.read_valid, bs.overflow, bs.underflow} !== {4'd0, 7'b1100000}) begin
            errors++;
            $display("FAIL reset_std_flags: got cnt=%0d e=%b ae=%b f=%b af=%b rv=%b ov=%b un=%b want cnt=0 e=1 ae=1 others 0",
                     bs.count, bs.mem_empty, bs.almost_empty, bs.mem_full, bs.almost_full,
                     bs.read_valid, bs.overflow, bs.underflow);
        end
        checks++;
        if (bs.read_data !== 8'h00) begin
            errors++; $display("FAIL reset_std_data: got %h want 00", bs.read_data);
        end
        checks++;
        if ({bf.read_valid, bf.read_data, bf.count} !== {1'b0, 8'h00, 4'd0}) begin
            errors++;
            $display("FAIL reset_fwft: got rv=%b data=%h cnt=%0d want rv=0 data=00 cnt=0",
                     bf.read_valid, bf.read_data, bf.count);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 8; i++) begin
            bs.write_en = 1'b1; bs.write_data = 8'h10 + 8'(i);
            step();
            checks++;
            if ({bs.count, bs.almost_full, bs.mem_full} !== {4'(i + 1), (i + 1 >= 6), (i + 1 == 8)}) begin
                errors++;
                $display("FAIL fill_%0d: got cnt=%0d af=%b f=%b want cnt=%0d af=%b f=%b", i,
                         bs.count, bs.almost_full, bs.mem_full, i + 1, (i + 1 >= 6), (i + 1 == 8));
            end
        end
        bs.write_data = 8'h99;
        step();
        bs.write_en = 1'b0;
        checks++;
        if ({bs.count, bs.overflow, bs.mem_full} !== {4'd8, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL overflow: got cnt=%0d ov=%b f=%b want cnt=8 ov=1 f=1",
                     bs.count, bs.overflow, bs.mem_full);
        end
        for (int i = 0; i < 8; i++) begin
            bs.read_en = 1'b1;
            step();
            checks++;
            if ({bs.read_valid, bs.read_data, bs.count} !== {1'b1, 8'h10 + 8'(i), 4'(7 - i)}) begin
                errors++;
                $display("FAIL drain_%0d: got rv=%b data=%h cnt=%0d want rv=1 data=%h cnt=%0d", i,
                         bs.read_valid, bs.read_data, bs.count, 8'h10 + 8'(i), 7 - i);
            end
        end
        bs.read_en = 1'b0;
        step();
        checks++;
        if ({bs.read_valid, bs.mem_empty, bs.underflow, bs.overflow} !== 4'b0101) begin
            errors++;
            $display("FAIL drain_idle: got rv=%b e=%b un=%b ov=%b want rv=0 e=1 un=0 ov=1",
                     bs.read_valid, bs.mem_empty, bs.underflow, bs.overflow);
        end
    endtask

    task automatic test_full_rw();
        logic [7:0] exp_q [$];
        std_flush();
        for (int i = 0; i < 8; i++) begin
            bs.write_en = 1'b1; bs.write_data = 8'h20 + 8'(i);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            bs.write_en = 1'b1; bs.read_en = 1'b1; bs.write_data = 8'h30 + 8'(i);
            step();
            checks++;
            if ({bs.count, bs.overflow, bs.read_valid, bs.read_data} !== {4'd8, 1'b0, 1'b1, 8'h20 + 8'(i)}) begin
                errors++;
                $display("FAIL full_rw_%0d: got cnt=%0d ov=%b rv=%b data=%h want cnt=8 ov=0 rv=1 data=%h", i,
                         bs.count, bs.overflow, bs.read_valid, bs.read_data, 8'h20 + 8'(i));
            end
        end
        exp_q = '{8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h30, 8'h31, 8'h32};
        bs.write_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bs.read_en = 1'b1;
            step();
            checks++;
            if ({bs.read_valid, bs.read_data} !== {1'b1, exp_q[i]}) begin
                errors++;
                $display("FAIL full_rw_drain_%0d: got rv=%b data=%h want rv=1 data=%h", i,
                         bs.read_valid, bs.read_data, exp_q[i]);
            end
        end
        bs.write_en = 1'b1; bs.read_en = 1'b1; bs.write_data = 8'h55;
        step();
        checks++;
        if ({bs.count, bs.underflow, bs.read_valid} !== {4'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL empty_rw: got cnt=%0d un=%b rv=%b want cnt=1 un=1 rv=0",
                     bs.count, bs.underflow, bs.read_valid);
        end
        bs.write_en = 1'b0;
        step();
        bs.read_en = 1'b0;
        checks++;
        if ({bs.read_valid, bs.read_data, bs.count} !== {1'b1, 8'h55, 4'd0}) begin
            errors++;
            $display("FAIL empty_rw_pop: got rv=%b data=%h cnt=%0d want rv=1 data=55 cnt=0",
                     bs.read_valid, bs.read_data, bs.count);
        end
    endtask

    task automatic test_wrap();
        int bad = 0;
        std_flush();
        for (int i = 0; i < 20; i++) begin
            bs.write_en = 1'b1; bs.read_en = 1'b0; bs.write_data = 8'(i);
            step();
            if (bs.count !== 4'd1) bad++;
            bs.write_en = 1'b0; bs.read_en = 1'b1;
            step();
            if ({bs.read_valid, bs.read_data, bs.count} !== {1'b1, 8'(i), 4'd0}) begin
                bad++;
                $display("FAIL wrap_%0d: got rv=%b data=%h cnt=%0d want rv=1 data=%h cnt=0", i,
                         bs.read_valid, bs.read_data, bs.count, 8'(i));
            end
        end
        bs.read_en = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL wrap_total: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_fwft();
        bf.write_en = 1'b1; bf.write_data = 8'hA5;
        step();
        bf.write_en = 1'b0;
        checks++;
        if ({bf.read_valid, bf.read_data} !== {1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL fwft_head: got rv=%b data=%h want rv=1 data=a5", bf.read_valid, bf.read_data);
        end
        bf.read_en = 1'b1;
        step();
        bf.read_en = 1'b0;
        checks++;
        if ({bf.read_valid, bf.read_data, bf.mem_empty} !== {1'b0, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL fwft_pop: got rv=%b data=%h e=%b want rv=0 data=00 e=1",
                     bf.read_valid, bf.read_data, bf.mem_empty);
        end
        bf.write_en = 1'b1; bf.write_data = 8'hB1;
        step();
        bf.write_data = 8'hB2;
        step();
        bf.write_en = 1'b0; bf.read_en = 1'b1;
        checks++;
        if ({bf.read_valid, bf.read_data, bf.count} !== {1'b1, 8'hB1, 4'd2}) begin
            errors++;
            $display("FAIL fwft_two_head: got rv=%b data=%h cnt=%0d want rv=1 data=b1 cnt=2",
                     bf.read_valid, bf.read_data, bf.count);
        end
        step();
        bf.read_en = 1'b0;
        checks++;
        if ({bf.read_valid, bf.read_data, bf.count} !== {1'b1, 8'hB2, 4'd1}) begin
            errors++;
            $display("FAIL fwft_next: got rv=%b data=%h cnt=%0d want rv=1 data=b2 cnt=1",
                     bf.read_valid, bf.read_data, bf.count);
        end
    endtask

    task automatic test_flush();
        std_flush();
        for (int i = 0; i < 9; i++) begin
            bs.write_en = 1'b1; bs.write_data = 8'h40 + 8'(i);
            step();
        end
        bs.write_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bs.read_en = 1'b1;
            step();
        end
        bs.read_en = 1'b0;
        checks++;
        if ({bs.count, bs.overflow} !== {4'd5, 1'b1}) begin
            errors++;
            $display("FAIL flush_setup: got cnt=%0d ov=%b want cnt=5 ov=1", bs.count, bs.overflow);
        end
        bs.flush = 1'b1; bs.write_en = 1'b1; bs.write_data = 8'hEE;
        step();
        std_idle();
        checks++;
        if ({bs.count, bs.mem_empty, bs.overflow, bs.read_valid, bs.read_data} !==
            {4'd0, 1'b1, 1'b0, 1'b0, 8'h42}) begin
            errors++;
            $display("FAIL flush: got cnt=%0d e=%b ov=%b rv=%b data=%h want cnt=0 e=1 ov=0 rv=0 data=42",
                     bs.count, bs.mem_empty, bs.overflow, bs.read_valid, bs.read_data);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            bs.write_en = 1'b1; bs.write_data = 8'h60 + 8'(i);
            step();
        end
        bs.read_en = 1'b1; bs.write_data = 8'h63;
        step();
        checks++;
        if ({bs.read_valid, bs.read_data, bs.count} !== {1'b1, 8'h60, 4'd3}) begin
            errors++;
            $display("FAIL burst: got rv=%b data=%h cnt=%0d want rv=1 data=60 cnt=3",
                     bs.read_valid, bs.read_data, bs.count);
        end
        #2 rst_l = 1'b0;
        #1;
        checks++;
        if ({bs.count, bs.mem_empty, bs.almost_empty, bs.mem_full, bs.almost_full,
             bs.read_valid, bs.overflow, bs.underflow, bs.read_data} !== {4'd0, 7'b1100000, 8'h00}) begin
            errors++;
            $display("FAIL reset_mid: got cnt=%0d e=%b ae=%b f=%b af=%b rv=%b ov=%b un=%b data=%h want reset values",
                     bs.count, bs.mem_empty, bs.almost_empty, bs.mem_full, bs.almost_full,
                     bs.read_valid, bs.overflow, bs.underflow, bs.read_data);
        end
        checks++;
        if ({bf.read_valid, bf.count} !== {1'b0, 4'd0}) begin
            errors++;
            $display("FAIL reset_mid_fwft: got rv=%b cnt=%0d want rv=0 cnt=0", bf.read_valid, bf.count);
        end
        std_idle();
        #3 rst_l = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_rw();
        test_wrap();
        test_fwft();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
